// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised video timing generator with a pixel-rate
// prescaler, free-running x/y counters and a delay line on sync/active that
// aligns them with a downstream frame-buffer read pipeline.
// Optional build macro VGA_TEST_PATTERN_EN adds an eight-bar colour test
// pattern output, aligned with the delayed active flag.
module vga_timing_gen #(
  parameter int CW         = 11,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  output logic          pixel_tick,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          h_sync,
  output logic          v_sync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0]   pattern_rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);

  // One extra bit so sync end points equal to 2^CW do not wrap to zero.
  localparam logic [CW:0] H_ACT    = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_START = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT    = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_START = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > (1 << CW)) begin : g_chk_h
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > (1 << CW)) begin : g_chk_v
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end
  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (PIPE_DELAY > 15 || PIPE_DELAY < 0) begin : g_chk_pipe
    $error("vga_timing_gen: PIPE_DELAY must be in 0..15");
  end

  logic [DW-1:0]       div_q, div_d;
  logic [CW-1:0]       x_q, x_d, y_q, y_d;
  logic                ls_q, ls_d, fs_q, fs_d;
  logic                tick;
  logic                hs_raw, vs_raw, act_raw;
  logic [PIPE_DELAY:0] hs_q, hs_d, vs_q, vs_d, act_q, act_d;

  // Pixel tick fires on the prescaler's last count; reset and enable gate it.
  always_comb begin
    tick  = enable && !reset && (div_q == DIV_LAST);
    div_d = div_q;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end
  end

  // Raster counters; line/frame strobes are registered so they line up with x=0.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d  = '0;
        ls_d = 1'b1;
        if (y_q == Y_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + CW'(1);
        end
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  // Decode the current position and shift it down the delay line on each tick.
  always_comb begin
    hs_raw  = ({1'b0, x_q} >= HS_START) && ({1'b0, x_q} < HS_END);
    vs_raw  = ({1'b0, y_q} >= VS_START) && ({1'b0, y_q} < VS_END);
    act_raw = ({1'b0, x_q} < H_ACT) && ({1'b0, y_q} < V_ACT);
    hs_d    = hs_q;
    vs_d    = vs_q;
    act_d   = act_q;
    if (tick) begin
      hs_d[0]  = hs_raw;
      vs_d[0]  = vs_raw;
      act_d[0] = act_raw;
      for (int i = 1; i <= PIPE_DELAY; i++) begin
        hs_d[i]  = hs_q[i-1];
        vs_d[i]  = vs_q[i-1];
        act_d[i] = act_q[i-1];
      end
    end
  end

  // State registers; stage value 0 means "not in sync / not active" (idle).
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      hs_q  <= '0;
      vs_q  <= '0;
      act_q <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
    end
  end

  assign pixel_tick  = tick;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign line_start  = ls_q && enable;
  assign frame_start = fs_q && enable;
  assign h_sync      = ~(hs_q[PIPE_DELAY] ^ H_POL);
  assign v_sync      = ~(vs_q[PIPE_DELAY] ^ V_POL);
  assign active      = act_q[PIPE_DELAY];

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [CW-1:0]             bar_idx;
  logic [2:0]                bar_raw;
  logic [PIPE_DELAY:0][2:0]  bar_q, bar_d;

  // Bar index travels with the active flag so colour and active stay aligned.
  always_comb begin
    bar_idx = x_q / CW'(BAR_W);
    bar_raw = (bar_idx > CW'(7)) ? 3'd7 : bar_idx[2:0];
    bar_d   = bar_q;
    if (tick) begin
      bar_d[0] = bar_raw;
      for (int i = 1; i <= PIPE_DELAY; i++) begin
        bar_d[i] = bar_q[i-1];
      end
    end
  end

  // Bar index delay registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      bar_q <= '0;
    end else begin
      bar_q <= bar_d;
    end
  end

  // Colour lookup: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    pattern_rgb = 12'h000;
    if (act_q[PIPE_DELAY]) begin
      case (bar_q[PIPE_DELAY])
        3'd0:    pattern_rgb = 12'hFFF;
        3'd1:    pattern_rgb = 12'hFF0;
        3'd2:    pattern_rgb = 12'h0FF;
        3'd3:    pattern_rgb = 12'h0F0;
        3'd4:    pattern_rgb = 12'hF0F;
        3'd5:    pattern_rgb = 12'hF00;
        3'd6:    pattern_rgb = 12'h00F;
        default: pattern_rgb = 12'h000;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, a tiny raster
// with active-high syncs and CLK_DIV=1, and 800x600 with CLK_DIV=3) share
// randomised reset/enable stimulus and are compared every clock against a
// model that derives everything from enabled-clock and pixel-tick counts.
module tb_vga_timing_gen;

  localparam int NI   = 3;
  localparam int NCYC = 20000;

  localparam int HA   [NI] = '{640, 8, 800};
  localparam int HF   [NI] = '{16,  2, 40};
  localparam int HS   [NI] = '{96,  3, 128};
  localparam int HB   [NI] = '{48,  2, 88};
  localparam int VA   [NI] = '{480, 4, 600};
  localparam int VF   [NI] = '{10,  1, 1};
  localparam int VS   [NI] = '{2,   2, 4};
  localparam int VB   [NI] = '{33,  1, 23};
  localparam int DIVS [NI] = '{2,   1, 3};
  localparam int PD   [NI] = '{2,   3, 0};
  localparam bit POL  [NI] = '{1'b0, 1'b1, 1'b1};

  logic clock = 1'b0;
  logic reset;
  logic enable;

  logic [NI-1:0]       pt_o, hs_o, vs_o, act_o, ls_o, fs_o;
  logic [NI-1:0][10:0] px_o, py_o;
`ifdef VGA_TEST_PATTERN_EN
  logic [NI-1:0][11:0] rgb_o;
  logic [11:0] bar_rgb [8];
`endif

  for (genvar k = 0; k < NI; k++) begin : g_dut
    vga_timing_gen #(
      .CW(11), .H_ACTIVE(HA[k]), .H_FP(HF[k]), .H_SYNC(HS[k]), .H_BP(HB[k]),
      .V_ACTIVE(VA[k]), .V_FP(VF[k]), .V_SYNC(VS[k]), .V_BP(VB[k]),
      .H_POL(POL[k]), .V_POL(POL[k]), .CLK_DIV(DIVS[k]), .PIPE_DELAY(PD[k])
    ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .pixel_tick  (pt_o[k]),
      .pixel_x     (px_o[k]),
      .pixel_y     (py_o[k]),
      .h_sync      (hs_o[k]),
      .v_sync      (vs_o[k]),
      .active      (act_o[k]),
      .line_start  (ls_o[k]),
      .frame_start (fs_o[k])
`ifdef VGA_TEST_PATTERN_EN
      ,
      .pattern_rgb (rgb_o[k])
`endif
    );
  end

  always #5 clock = ~clock;

  // Model state: enabled clocks and pixel ticks since the last reset.
  int e_m [NI];
  int n_m [NI];
  bit ls_m [NI];
  bit fs_m [NI];
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int  ht, vt;
    bit  tk;
    ht = HA[k] + HF[k] + HS[k] + HB[k];
    vt = VA[k] + VF[k] + VS[k] + VB[k];
    if (reset) begin
      e_m[k] = 0; n_m[k] = 0; ls_m[k] = 0; fs_m[k] = 0;
    end else if (enable) begin
      tk = (e_m[k] % DIVS[k]) == DIVS[k] - 1;
      e_m[k]++;
      if (tk) n_m[k]++;
      ls_m[k] = tk && (n_m[k] % ht == 0);
      fs_m[k] = tk && (n_m[k] % (ht * vt) == 0);
    end else begin
      ls_m[k] = 0; fs_m[k] = 0;
    end
  endtask

  task automatic check_inst(input int k);
    int ht, vt, m, xs, ys;
    bit hs_r, vs_r, act_r;
    ht = HA[k] + HF[k] + HS[k] + HB[k];
    vt = VA[k] + VF[k] + VS[k] + VB[k];
    // Sync/active show the position from PIPE_DELAY+1 ticks ago.
    m = n_m[k] - (PD[k] + 1);
    xs = 0; ys = 0; hs_r = 0; vs_r = 0; act_r = 0;
    if (m >= 0) begin
      xs    = m % ht;
      ys    = (m / ht) % vt;
      hs_r  = (xs >= HA[k] + HF[k]) && (xs < HA[k] + HF[k] + HS[k]);
      vs_r  = (ys >= VA[k] + VF[k]) && (ys < VA[k] + VF[k] + VS[k]);
      act_r = (xs < HA[k]) && (ys < VA[k]);
    end
    check_val($sformatf("tick%0d", k), pt_o[k],
              enable && !reset && ((e_m[k] % DIVS[k]) == DIVS[k] - 1));
    check_val($sformatf("px%0d", k), px_o[k], n_m[k] % ht);
    check_val($sformatf("py%0d", k), py_o[k], (n_m[k] / ht) % vt);
    check_val($sformatf("hsync%0d", k), hs_o[k], hs_r ? POL[k] : !POL[k]);
    check_val($sformatf("vsync%0d", k), vs_o[k], vs_r ? POL[k] : !POL[k]);
    check_val($sformatf("active%0d", k), act_o[k], act_r);
    check_val($sformatf("line_start%0d", k), ls_o[k], enable && ls_m[k]);
    check_val($sformatf("frame_start%0d", k), fs_o[k], enable && fs_m[k]);
`ifdef VGA_TEST_PATTERN_EN
    check_val($sformatf("rgb%0d", k), rgb_o[k],
              act_r ? bar_rgb[(xs / (HA[k] / 8)) > 7 ? 7 : (xs / (HA[k] / 8))] : 12'h000);
`endif
  endtask

  initial begin
`ifdef VGA_TEST_PATTERN_EN
    bar_rgb = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif
    for (int k = 0; k < NI; k++) begin
      e_m[k] = 0; n_m[k] = 0; ls_m[k] = 0; fs_m[k] = 0;
    end
    reset  = 1'b1;
    enable = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);
      for (int k = 0; k < NI; k++) check_inst(k);
      reset = (cyc < 3) || (cyc >= 9000 && cyc < 9002) || ($urandom_range(0, 4999) == 0);
      if (cyc >= 12000 && cyc < 12010)
        enable = 1'b0;
      else if (cyc < 4000)
        enable = 1'b1;
      else
        enable = ($urandom_range(0, 15) != 0);
      @(posedge clock);
      for (int k = 0; k < NI; k++) model_step(k);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
